// File: rtl/cpu_pkg.sv
// Shared constants for the 5-stage MIPS core: register address width,
// PC-source mux encodings and the sequencer FSM states.
package cpu_pkg;

  localparam int unsigned REG_AW = 5;

  localparam logic [1:0] PCSEL_SEQ = 2'b00;
  localparam logic [1:0] PCSEL_BR  = 2'b01;
  localparam logic [1:0] PCSEL_J   = 2'b10;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear beats increment.
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencer: load-use / branch-operand stalls, taken-redirect
// flushes and PC-source selection, plus run-time performance counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_AW = cpu_pkg::REG_AW,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic              cnt_clr_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_uses_rt_i,
  input  logic              id_branch_i,
  input  logic              id_equal_i,
  input  logic              id_jump_i,
  input  logic              ex_memread_i,
  input  logic              ex_regwrite_i,
  input  logic [REG_AW-1:0] ex_wr_addr_i,
  input  logic              mem_memread_i,
  input  logic [REG_AW-1:0] mem_wr_addr_i,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              idex_bubble_o,
  output logic              ifid_flush_o,
  output logic [1:0]        pc_sel_o,
  output logic              running_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o,
  output logic [CNT_W-1:0]  cycle_cnt_o
);

  import cpu_pkg::*;

  logic [0:0] state;
  logic [0:0] state_nxt;
  logic       load_use;
  logic       br_ex;
  logic       br_mem;
  logic       stall;
  logic       run;

  // $zero never carries a hazard since it is never really written.
  function automatic logic reg_match(input logic [REG_AW-1:0] a,
                                     input logic [REG_AW-1:0] rs,
                                     input logic [REG_AW-1:0] rt,
                                     input logic              uses_rt);
    return (a != '0) && ((a == rs) || (uses_rt && (a == rt)));
  endfunction

  assign load_use = ex_memread_i && reg_match(ex_wr_addr_i, id_rs_i, id_rt_i, id_uses_rt_i);
  // Branches resolve in ID, so an ALU result still in EX or a load in MEM must wait.
  assign br_ex    = id_branch_i && ex_regwrite_i &&
                    reg_match(ex_wr_addr_i, id_rs_i, id_rt_i, id_uses_rt_i);
  assign br_mem   = id_branch_i && mem_memread_i &&
                    reg_match(mem_wr_addr_i, id_rs_i, id_rt_i, id_uses_rt_i);
  assign stall    = load_use | br_ex | br_mem;
  assign run      = (state == ST_RUN);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = start_i ? ST_RUN : ST_IDLE;
    pc_write_o    = 1'b0;
    ifid_write_o  = 1'b0;
    idex_bubble_o = 1'b1;
    ifid_flush_o  = 1'b0;
    pc_sel_o      = PCSEL_SEQ;
    running_o     = 1'b0;
    if (run) begin
      running_o = 1'b1;
      if (!stall) begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        idex_bubble_o = 1'b0;
        if (id_jump_i) begin
          pc_sel_o     = PCSEL_J;
          ifid_flush_o = 1'b1;
        end else if (id_branch_i && id_equal_i) begin
          pc_sel_o     = PCSEL_BR;
          ifid_flush_o = 1'b1;
        end
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk(clk_i), .rst_n(rst_n_i), .inc(run), .clr(cnt_clr_i), .cnt(cycle_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk_i), .rst_n(rst_n_i), .inc(run && stall), .clr(cnt_clr_i), .cnt(stall_cnt_o)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk_i), .rst_n(rst_n_i), .inc(ifid_flush_o), .clr(cnt_clr_i), .cnt(flush_cnt_o)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; a second copy with 4-bit
// counters shares the stimulus to exercise saturation.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       cnt_clr;
  logic [4:0] id_rs, id_rt, ex_wr_addr, mem_wr_addr;
  logic       id_uses_rt, id_branch, id_equal, id_jump;
  logic       ex_memread, ex_regwrite, mem_memread;

  logic        pc_write, ifid_write, idex_bubble, ifid_flush, running;
  logic [1:0]  pc_sel;
  logic [31:0] stall_cnt, flush_cnt, cycle_cnt;

  logic        pc_write4, ifid_write4, idex_bubble4, ifid_flush4, running4;
  logic [1:0]  pc_sel4;
  logic [3:0]  stall_cnt4, flush_cnt4, cycle_cnt4;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .cnt_clr_i(cnt_clr),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
    .id_branch_i(id_branch), .id_equal_i(id_equal), .id_jump_i(id_jump),
    .ex_memread_i(ex_memread), .ex_regwrite_i(ex_regwrite), .ex_wr_addr_i(ex_wr_addr),
    .mem_memread_i(mem_memread), .mem_wr_addr_i(mem_wr_addr),
    .pc_write_o(pc_write), .ifid_write_o(ifid_write), .idex_bubble_o(idex_bubble),
    .ifid_flush_o(ifid_flush), .pc_sel_o(pc_sel), .running_o(running),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt), .cycle_cnt_o(cycle_cnt)
  );

  pipeline_hazard_ctrl #(.CNT_W(4)) dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .cnt_clr_i(cnt_clr),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
    .id_branch_i(id_branch), .id_equal_i(id_equal), .id_jump_i(id_jump),
    .ex_memread_i(ex_memread), .ex_regwrite_i(ex_regwrite), .ex_wr_addr_i(ex_wr_addr),
    .mem_memread_i(mem_memread), .mem_wr_addr_i(mem_wr_addr),
    .pc_write_o(pc_write4), .ifid_write_o(ifid_write4), .idex_bubble_o(idex_bubble4),
    .ifid_flush_o(ifid_flush4), .pc_sel_o(pc_sel4), .running_o(running4),
    .stall_cnt_o(stall_cnt4), .flush_cnt_o(flush_cnt4), .cycle_cnt_o(cycle_cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_hazard_inputs();
    id_rs = '0; id_rt = '0; id_uses_rt = 1'b0;
    id_branch = 1'b0; id_equal = 1'b0; id_jump = 1'b0;
    ex_memread = 1'b0; ex_regwrite = 1'b0; ex_wr_addr = '0;
    mem_memread = 1'b0; mem_wr_addr = '0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; cnt_clr = 1'b0;
    clear_hazard_inputs();
    #3;
    chk("rst_running", 32'(running), 0);
    chk("rst_pc_write", 32'(pc_write), 0);
    chk("rst_bubble", 32'(idex_bubble), 1);
    chk("rst_cycle_cnt", cycle_cnt, 0);
    #9 rst_n = 1'b1;

    // Stay idle three edges
    repeat (3) step();
    chk("idle_running", 32'(running), 0);
    chk("idle_pc_write", 32'(pc_write), 0);
    chk("idle_ifid_write", 32'(ifid_write), 0);
    chk("idle_bubble", 32'(idex_bubble), 1);
    chk("idle_cycle_cnt", cycle_cnt, 0);
    chk("idle_stall_cnt", stall_cnt, 0);

    start = 1'b1;
    step();
    chk("run_running", 32'(running), 1);
    chk("run_pc_write", 32'(pc_write), 1);
    chk("run_bubble", 32'(idex_bubble), 0);
    chk("run_cycle0", cycle_cnt, 0);
    step();
    step();
    chk("run_cycle2", cycle_cnt, 2);

    cnt_clr = 1'b1;
    step();
    chk("clr_beats_inc", cycle_cnt, 0);
    cnt_clr = 1'b0;

    // Load-use on rs
    ex_memread = 1'b1; ex_wr_addr = 5'd8; id_rs = 5'd8;
    #1;
    chk("lu_pc_write", 32'(pc_write), 0);
    chk("lu_ifid_write", 32'(ifid_write), 0);
    chk("lu_bubble", 32'(idex_bubble), 1);
    step();
    chk("lu_stall_cnt", stall_cnt, 1);
    ex_memread = 1'b0;
    #1;
    chk("lu_release_pc_write", 32'(pc_write), 1);
    chk("lu_release_bubble", 32'(idex_bubble), 0);

    // rt only matters when the instruction reads rt
    id_rs = 5'd3; id_rt = 5'd8; ex_memread = 1'b1; ex_wr_addr = 5'd8; id_uses_rt = 1'b0;
    #1;
    chk("rt_unused_pc_write", 32'(pc_write), 1);
    id_uses_rt = 1'b1;
    #1;
    chk("rt_used_pc_write", 32'(pc_write), 0);

    // ALU result in EX feeding a branch stalls, equal ignored
    clear_hazard_inputs();
    id_branch = 1'b1; id_equal = 1'b1; id_rs = 5'd5; ex_regwrite = 1'b1; ex_wr_addr = 5'd5;
    #1;
    chk("brex_pc_write", 32'(pc_write), 0);
    chk("brex_pc_sel", 32'(pc_sel), 0);
    chk("brex_flush", 32'(ifid_flush), 0);
    id_branch = 1'b0; id_equal = 1'b0;
    #1;
    chk("alu_fwd_no_stall", 32'(pc_write), 1);
    clear_hazard_inputs();

    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;

    // Branch-on-load: two stall cycles then taken
    id_branch = 1'b1; id_rs = 5'd9; id_rt = 5'd1; id_uses_rt = 1'b1;
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_wr_addr = 5'd9;
    #1;
    chk("bl_a_pc_write", 32'(pc_write), 0);
    step();
    ex_memread = 1'b0; ex_regwrite = 1'b0; ex_wr_addr = '0;
    mem_memread = 1'b1; mem_wr_addr = 5'd9;
    #1;
    chk("bl_b_pc_write", 32'(pc_write), 0);
    step();
    mem_memread = 1'b0; mem_wr_addr = '0; id_equal = 1'b1;
    #1;
    chk("bl_c_pc_sel", 32'(pc_sel), 1);
    chk("bl_c_flush", 32'(ifid_flush), 1);
    chk("bl_c_pc_write", 32'(pc_write), 1);
    step();
    chk("bl_stall_cnt", stall_cnt, 2);
    chk("bl_flush_cnt", flush_cnt, 1);
    chk("bl_cycle_cnt", cycle_cnt, 3);

    // Jump beats a taken branch
    clear_hazard_inputs();
    id_jump = 1'b1; id_branch = 1'b1; id_equal = 1'b1;
    #1;
    chk("jmp_pc_sel", 32'(pc_sel), 2);
    chk("jmp_flush", 32'(ifid_flush), 1);
    step();
    chk("jmp_flush_cnt", flush_cnt, 2);

    // $zero destination is not a hazard
    clear_hazard_inputs();
    ex_memread = 1'b1; ex_wr_addr = 5'd0; id_rs = 5'd0;
    #1;
    chk("zero_pc_write", 32'(pc_write), 1);
    chk("zero_bubble", 32'(idex_bubble), 0);
    step();
    chk("zero_stall_cnt", stall_cnt, 2);

    // Saturation on the 4-bit copy
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    ex_wr_addr = 5'd8; id_rs = 5'd8;
    repeat (20) step();
    chk("sat_stall_cnt4", 32'(stall_cnt4), 15);
    chk("sat_cycle_cnt4", 32'(cycle_cnt4), 15);
    chk("sat_stall_cnt32", stall_cnt, 20);
    step();
    chk("sat_hold_cnt4", 32'(stall_cnt4), 15);
    cnt_clr = 1'b1;
    step();
    chk("sat_clr_cnt4", 32'(stall_cnt4), 0);
    chk("sat_clr_cnt32", stall_cnt, 0);
    cnt_clr = 1'b0;

    // Async reset in the middle of a stall cycle
    step();
    chk("pre_rst_stall_cnt", stall_cnt, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_running", 32'(running), 0);
    chk("arst_pc_write", 32'(pc_write), 0);
    chk("arst_ifid_write", 32'(ifid_write), 0);
    chk("arst_bubble", 32'(idex_bubble), 1);
    chk("arst_stall_cnt", stall_cnt, 0);
    chk("arst_cycle_cnt", cycle_cnt, 0);
    #2 rst_n = 1'b1;
    clear_hazard_inputs();

    step();
    chk("rerun_running", 32'(running), 1);
    step();
    chk("rerun_cycle1", cycle_cnt, 1);
    start = 1'b0;
    step();
    step();
    chk("stop_running", 32'(running), 0);
    chk("stop_cycle_hold", cycle_cnt, 2);
    id_jump = 1'b1;
    #1;
    chk("idle_jump_pc_sel", 32'(pc_sel), 0);
    chk("idle_jump_flush", 32'(ifid_flush), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage MIPS CPU. Gates PC and IF/ID writes, injects ID/EX bubbles, and flushes IF/ID on taken branch/jump resolved in ID. It runs a start/run FSM and keeps saturating stall, flush and cycle counters that benches read hierarchically. Sits beside the ID stage and drives PC, IF/ID, ID/EX control and the PC-source mux.

Parameters:
REG_AW, 5, register-address width
CNT_W, 32, width of each performance counter

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
start_i  in  1  run enable; sampled on each rising edge
cnt_clr_i  in  1  synchronous clear of all counters
id_rs_i  in  REG_AW  rs field of instruction in ID
id_rt_i  in  REG_AW  rt field of instruction in ID
id_uses_rt_i  in  1  ID instruction reads rt (R-type, beq, sw)
id_branch_i  in  1  ID instruction is beq
id_equal_i  in  1  ID comparator: rs value == rt value
id_jump_i  in  1  ID instruction is j
ex_memread_i  in  1  ID/EX holds a load
ex_regwrite_i  in  1  ID/EX writes a register
ex_wr_addr_i  in  REG_AW  ID/EX destination register
mem_memread_i  in  1  EX/MEM holds a load
mem_wr_addr_i  in  REG_AW  EX/MEM destination register
pc_write_o  out  1  PC load enable
ifid_write_o  out  1  IF/ID load enable
idex_bubble_o  out  1  zero ID/EX control fields
ifid_flush_o  out  1  clear IF/ID to nop
pc_sel_o  out  2  00 PC+4, 01 branch target, 10 jump target
running_o  out  1  FSM in RUN
stall_cnt_o  out  CNT_W  data-hazard stall cycles
flush_cnt_o  out  CNT_W  taken-redirect flushes
cycle_cnt_o  out  CNT_W  cycles spent in RUN

Behaviour:
- FSM states: IDLE and RUN. Async reset sets IDLE and clears all counters. Edge with start_i=1 moves to RUN. Edge with start_i=0 moves to IDLE. Counters hold in IDLE.
- IDLE outputs: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, ifid_flush_o=0, pc_sel_o=00, running_o=0. These are also the values during reset.
- RUN outputs are combinational from current inputs (0-cycle latency). Registers only in FSM and counters.
- Match rule: match(a) = (a != 0) && (a == id_rs_i || (id_uses_rt_i && a == id_rt_i)).
- load_use = ex_memread_i && match(ex_wr_addr_i).
- br_ex = id_branch_i && ex_regwrite_i && match(ex_wr_addr_i).
- br_mem = id_branch_i && mem_memread_i && match(mem_wr_addr_i).
- stall = load_use | br_ex | br_mem.
- On stall: pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, ifid_flush_o=0, pc_sel_o=00. id_equal_i is ignored while stalled.
- No stall: pc_write_o=1, ifid_write_o=1, idex_bubble_o=0.
  - id_jump_i → pc_sel_o=10, ifid_flush_o=1.
  - else id_branch_i && id_equal_i → pc_sel_o=01, ifid_flush_o=1.
  - else pc_sel_o=00, ifid_flush_o=0.
  - Jump has priority if both branch and jump are asserted.
- Counters, in RUN only, per edge:
  - cycle_cnt +1.
  - stall_cnt +1 if stall.
  - flush_cnt +1 if ifid_flush_o.
- Counters saturate at all-ones with no wrap.
- cnt_clr_i zeroes all counters and wins over a same-edge increment. It is honoured in either state.
- Async reset asserted mid-run: outputs go to IDLE values immediately and counters go to 0.
- Branch-on-load costs 2 stall cycles (EX then MEM). Branch-on-ALU result costs 1.

Decomposition:
- Shared package cpu_pkg holds: REG_AW; pc_sel encodings PCSEL_SEQ=2'b00, PCSEL_BR=2'b01, PCSEL_J=2'b10; FSM state constants.
- One sub-module: sat_counter (CNT_W, inc, clr, async active-low reset), instantiated three times.

Test Plan:
1. Reset, start_i=0 for 3 cycles → running_o=0, pc_write_o=0, idex_bubble_o=1, all counters 0. Raise start_i → after next edge running_o=1, pc_write_o=1, cycle_cnt increments each edge.
2. ex_memread_i=1, ex_wr_addr_i=8, id_rs_i=8 for one cycle → pc_write_o=0, ifid_write_o=0, idex_bubble_o=1, stall_cnt=1. Next cycle with memread=0 → normal flow.
3. beq rs=9: cycle A ex_memread_i=1, ex_wr_addr_i=9; cycle B mem_memread_i=1, mem_wr_addr_i=9; cycle C id_equal_i=1 → stall in A and B (stall_cnt=2), then C gives pc_sel_o=01, ifid_flush_o=1, flush_cnt=1.
4. id_jump_i=1 and id_branch_i=1, id_equal_i=1 with no hazard → pc_sel_o=10, ifid_flush_o=1. ex_memread_i=1, ex_wr_addr_i=0, id_rs_i=0 → no stall.
5. CNT_W=4, 20 consecutive load-use cycles → stall_cnt_o=15 and holds. cnt_clr_i with stall → 0 on that edge.
6. Drop rst_n_i mid-stall between edges → outputs go to IDLE values immediately and counters read 0 before the next clock edge.
